// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - ID-stage request and hazard/forwarding response bundle
interface hazard_fwd_ctrl_if #(parameter int REGW = 3);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic [REGW-1:0] id_rd;
  logic            id_wr_en;
  logic            id_is_load;
  logic            ex_taken;
  logic            stall;
  logic            flush;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [15:0]     stall_cnt;
  logic [15:0]     flush_cnt;
  logic            err;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load, ex_taken,
    input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt, err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load, ex_taken,
    output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt, err
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - load-use stall, branch flush and ALU operand forwarding control
module hazard_fwd_ctrl #(
  parameter int REGW = 3
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            wr_en;
    logic            is_load;
  } stage_t;

  state_t      state, state_nxt;
  stage_t      ex_q, mem_q, wb_q, ex_d;
  logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        err_q;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, flush_i, stall_raw, stall_i, advance, err_set;

  function automatic logic hit(input logic used, input stage_t s, input logic [REGW-1:0] src);
    return used & s.valid & s.wr_en & (s.rd == src);
  endfunction

  // Youngest producer (EX) takes priority over MEM.
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m);
    if (ex_m)  return 2'b10;
    if (mem_m) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    rs_ex     = hit(bus.id_rs_used, ex_q, bus.id_rs);
    rt_ex     = hit(bus.id_rt_used, ex_q, bus.id_rt);
    rs_mem    = hit(bus.id_rs_used, mem_q, bus.id_rs);
    rt_mem    = hit(bus.id_rt_used, mem_q, bus.id_rt);
    load_use  = bus.id_valid & ex_q.is_load & (rs_ex | rt_ex);
    // EX is a bubble while in FLUSH, so a taken indication there is stale.
    flush_i   = bus.ex_taken & ex_q.valid & (state != FLUSH);
    stall_raw = load_use & ~flush_i;
    stall_i   = stall_raw & (state != LU_STALL);
    advance   = bus.id_valid & ~stall_i & ~flush_i;
    err_set   = (stall_raw & (state == LU_STALL)) | (bus.ex_taken & ~ex_q.valid & (state == RUN));

    ex_d      = '0;
    fwd_a_d   = 2'b00;
    fwd_b_d   = 2'b00;
    if (advance) begin
      ex_d    = '{valid: 1'b1, rd: bus.id_rd, wr_en: bus.id_wr_en, is_load: bus.id_is_load};
      fwd_a_d = fwd_sel(rs_ex, rs_mem);
      fwd_b_d = fwd_sel(rt_ex, rt_mem);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (flush_i)      state_nxt = FLUSH;
        else if (stall_i) state_nxt = LU_STALL;
      end
      LU_STALL: state_nxt = RUN;
      FLUSH:    state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state   <= state_nxt;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (stall_i && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_i && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
      if (err_set) err_q <= 1'b1;
    end
  end

  // WB is tracked for completeness; the write-through register file covers WB-to-ID.
  logic unused_shadow;
  assign unused_shadow = &{1'b0, wb_q, mem_q.is_load};

  assign bus.stall     = stall_i;
  assign bus.flush     = flush_i;
  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed and random checks against an in-flight instruction queue model
module tb_hazard_fwd_ctrl;
  localparam int REGW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REGW(REGW)) bus();
  hazard_fwd_ctrl #(.REGW(REGW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  slot_t pipe[$];
  bit    in_lu, in_fl, m_err, exp_stall;
  int    m_fwd_a, m_fwd_b, m_scnt, m_fcnt;
  bit    last_stall, last_flush;

  function automatic void model_reset();
    slot_t b = '{0, 0, 0, 0};
    pipe = {};
    for (int i = 0; i < 3; i++) pipe.push_back(b);
    in_lu = 0; in_fl = 0; m_err = 0; exp_stall = 0;
    m_fwd_a = 0; m_fwd_b = 0; m_scnt = 0; m_fcnt = 0;
  endfunction

  // 2: newest in-flight writer of src is one ahead, 1: two ahead, 0: none.
  function automatic int producer(input bit used, input int src);
    if (!used) return 0;
    if (pipe[0].v && pipe[0].wr && pipe[0].rd == src) return 2;
    if (pipe[1].v && pipe[1].wr && pipe[1].rd == src) return 1;
    return 0;
  endfunction

  task automatic drive_idle();
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_rd = '0; bus.id_wr_en = 0; bus.id_is_load = 0; bus.ex_taken = 0;
  endtask

  task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                      input int rd, input bit wr, input bit ld, input bit taken);
    bit m_flush, lu, raw, m_stall, in_run, adv;
    slot_t s;
    check("fwd_a", bus.fwd_a, m_fwd_a);
    check("fwd_b", bus.fwd_b, m_fwd_b);
    check("stall_cnt", bus.stall_cnt, m_scnt);
    check("flush_cnt", bus.flush_cnt, m_fcnt);
    check("err", bus.err, m_err);
    bus.id_valid = v; bus.id_rs = rs[REGW-1:0]; bus.id_rt = rt[REGW-1:0];
    bus.id_rs_used = rsu; bus.id_rt_used = rtu; bus.id_rd = rd[REGW-1:0];
    bus.id_wr_en = wr; bus.id_is_load = ld; bus.ex_taken = taken;
    #1;
    in_run  = !in_lu && !in_fl;
    m_flush = taken && pipe[0].v && !in_fl;
    lu      = v && pipe[0].v && pipe[0].ld && (producer(rsu, rs) == 2 || producer(rtu, rt) == 2);
    raw     = lu && !m_flush;
    m_stall = raw && !in_lu;
    last_stall = bus.stall;
    last_flush = bus.flush;
    check("stall", bus.stall, m_stall);
    check("flush", bus.flush, m_flush);
    if ((raw && in_lu) || (taken && !pipe[0].v && in_run)) m_err = 1;
    if (m_stall && m_scnt < 65535) m_scnt++;
    if (m_flush && m_fcnt < 65535) m_fcnt++;
    adv     = v && !m_stall && !m_flush;
    m_fwd_a = adv ? producer(rsu, rs) : 0;
    m_fwd_b = adv ? producer(rtu, rt) : 0;
    s = adv ? '{1, rd, wr, ld} : '{0, 0, 0, 0};
    void'(pipe.pop_back());
    pipe.push_front(s);
    in_fl = in_run && m_flush;
    in_lu = in_run && m_stall;
    exp_stall = m_stall;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic add(input int rd, input int rs, input int rt);
    step(1, rs, rt, 1, 1, rd, 1, 0, 0);
  endtask

  task automatic load(input int rd, input int rs);
    step(1, rs, 0, 1, 0, rd, 1, 1, 0);
  endtask

  initial begin
    int rv, rrs, rrt, rrd;
    bit rsu, rtu, rwr, rld;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_stall", bus.stall, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_fwd_a", bus.fwd_a, 0);
    check("rst_fwd_b", bus.fwd_b, 0);
    check("rst_scnt", bus.stall_cnt, 0);
    check("rst_fcnt", bus.flush_cnt, 0);
    check("rst_err", bus.err, 0);
    rst = 1;

    add(1, 2, 3);
    add(2, 1, 3);
    check("exmem_fwd_a", bus.fwd_a, 2);
    check("exmem_fwd_b", bus.fwd_b, 0);
    check("exmem_nostall", last_stall, 0);
    idle(2);

    add(1, 2, 3);
    add(6, 7, 7);
    add(4, 5, 1);
    check("memwb_fwd_a", bus.fwd_a, 0);
    check("memwb_fwd_b", bus.fwd_b, 1);
    idle(2);

    load(2, 5);
    add(3, 2, 2);
    check("lu_stall1", last_stall, 1);
    add(3, 2, 2);
    check("lu_stall2", last_stall, 0);
    check("lu_fwd_a", bus.fwd_a, 1);
    check("lu_fwd_b", bus.fwd_b, 1);
    check("lu_scnt", bus.stall_cnt, 1);
    idle(2);

    load(4, 5);
    step(1, 4, 4, 1, 1, 6, 1, 0, 1);
    check("fl_flush", last_flush, 1);
    check("fl_stall", last_stall, 0);
    check("fl_fcnt", bus.flush_cnt, 1);
    step(1, 6, 4, 1, 1, 7, 1, 0, 1);
    check("fl_ignored", last_flush, 0);
    check("fl_bubble_a", bus.fwd_a, 0);
    check("fl_bubble_b", bus.fwd_b, 1);
    check("fl_err", bus.err, 0);
    idle(2);

    add(1, 2, 3);
    step(1, 5, 1, 1, 0, 4, 1, 0, 0);
    check("imm_fwd_b", bus.fwd_b, 0);
    idle(2);

    load(2, 5);
    add(3, 2, 2);
    #2 rst = 0;
    #1;
    check("mid_rst_stall", bus.stall, 0);
    check("mid_rst_flush", bus.flush, 0);
    check("mid_rst_fwd_a", bus.fwd_a, 0);
    check("mid_rst_scnt", bus.stall_cnt, 0);
    check("mid_rst_fcnt", bus.flush_cnt, 0);
    check("mid_rst_err", bus.err, 0);
    drive_idle();
    @(negedge clk);
    model_reset();
    rst = 1;
    add(3, 2, 2);
    check("post_rst_stall", last_stall, 0);
    idle(1);

    rv = 0; rrs = 0; rrt = 0; rrd = 0; rsu = 0; rtu = 0; rwr = 0; rld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall) begin
        rv  = ($urandom_range(0, 4) != 0) ? 1 : 0;
        rrs = $urandom_range(0, 7);
        rrt = $urandom_range(0, 7);
        rrd = $urandom_range(0, 7);
        rsu = $urandom_range(0, 3) != 0;
        rtu = $urandom_range(0, 1) != 0;
        rwr = $urandom_range(0, 3) != 0;
        rld = $urandom_range(0, 2) == 0;
      end
      step(rv[0], rrs, rrt, rsu, rtu, rrd, rwr, rld, $urandom_range(0, 5) == 0);
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter REGW, default 3, meaning register-specifier width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REGW  source specifiers.
- id_rs_used, id_rt_used  in  1  source is read as ALU operand (id_rt_used=0 for immediate forms).
- id_rd  in  REGW  destination specifier.
- id_wr_en  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a memory load.
- ex_taken  in  1  BranchJumpTaken from execute, current cycle.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- flush  out  1  squash IF/ID and ID/EX contents.
- fwd_a, fwd_b  out  2  ForwardALUOp1/2 for the instruction now in EX: 00 register, 01 MEM/WB result, 10 EX/MEM result.
- stall_cnt, flush_cnt  out  16  saturating event counters.
- err  out  1  sticky internal-consistency error.

Function
REQ-003 SHALL keep a shadow pipeline of three stages (EX, MEM, WB), each holding valid, rd, wr_en, is_load.
REQ-004 Every cycle SHALL shift WB<=MEM, MEM<=EX; EX<=ID fields when the ID instruction advances, else EX<=bubble (valid=0).
REQ-005 The ID instruction advances when id_valid=1, stall=0, flush=0.
REQ-006 Source match SHALL require the source's used bit, stage valid=1 and wr_en=1, and equal specifiers.
REQ-007 fwd_a/fwd_b SHALL be computed in ID and registered into EX on the advance edge: EX-stage match -> 10, else MEM-stage match -> 01, else 00. The youngest producer wins.
REQ-008 On a non-advancing cycle fwd_a/fwd_b SHALL register 00.
REQ-009 Load-use: stall SHALL be asserted combinationally when shadow EX is_load=1 and matches a used ID source.
REQ-010 FSM states SHALL be RUN, LU_STALL, FLUSH.
- RUN->LU_STALL on load-use.
- RUN->FLUSH on flush.
- LU_STALL->RUN after exactly one cycle.
- FLUSH->RUN after one cycle.
REQ-011 In LU_STALL, stall SHALL be 0. The load has moved to MEM, so the next advance uses fwd 01.
REQ-012 flush SHALL equal ex_taken AND shadow EX valid. flush=1 SHALL force stall=0 and EX<=bubble.
REQ-013 On simultaneous load-use and flush, flush SHALL win, and the FSM SHALL enter FLUSH.
REQ-014 While in FLUSH, ex_taken SHALL be ignored, because the EX slot is a bubble.
REQ-015 stall_cnt SHALL increment on each cycle with stall=1; flush_cnt SHALL increment on each cycle with flush=1. Both saturate at 16'hFFFF, with no wrap.
REQ-016 err SHALL set when stall=1 while the FSM is in LU_STALL, or when ex_taken=1 while shadow EX valid=0 in RUN. err SHALL clear only on reset.
REQ-017 WB-to-ID hazards are not handled here; the register file SHALL be write-through.
REQ-018 Register 0 is not special; matches on it forward normally.

Reset
REQ-019 While rst=0, all shadow valids SHALL be 0, the FSM SHALL be in RUN, and fwd_a=fwd_b=00, stall=0, flush=0, both counters 0, err=0.
REQ-020 Reset SHALL act asynchronously on assertion. Deassertion takes effect at the next clk edge.
REQ-021 Reset mid-stall or mid-flush SHALL discard state. The first post-reset cycle is RUN with an empty pipeline.

Verification
REQ-022 Back-to-back ADD r1 then ADD r2,r1,r3 -> second instruction in EX has fwd_a=10, fwd_b=00, stall never 1.
REQ-023 ADD r1, unrelated op, then SUB r4,r5,r1 -> in EX fwd_b=01, fwd_a=00.
REQ-024 LD r2 then ADD r3,r2,r2 -> stall=1 for exactly one cycle, then ADD reaches EX with fwd_a=fwd_b=01; stall_cnt=1.
REQ-025 ex_taken=1 with a valid EX while the ID instruction is a load-use dependent -> flush=1, stall=0, FSM FLUSH, next EX valid=0, flush_cnt=1.
REQ-026 ADDI r1 with id_rt_used=0 after a write to rt's specifier -> fwd_b=00.
REQ-027 Assert rst=0 mid-LU_STALL -> all outputs immediately 0/00, and the next instruction advances with no stall.
